// File: rtl/dtack_wait_pkg.sv
// dtack_wait_pkg: shared FSM encoding and defaults
// for the dtack_wait_gen wait-state generator.
package dtack_wait_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_EXTW  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_COUNT = S_COUNT,
    ST_EXTW  = S_EXTW,
    ST_ACK   = S_ACK
  } state_t;

  localparam int NUM_ZONES_DEF   = 4;
  localparam int CNT_W_DEF       = 3;
  localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/dtack_zone_prio.sv
// dtack_zone_prio: picks the lowest-index asserted
// zone and forwards its wait count and ext flag.
module dtack_zone_prio
  import dtack_wait_pkg::*;
#(
  parameter int NUM_ZONES = NUM_ZONES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic [NUM_ZONES-1:0]       n_zone,
  input  logic [NUM_ZONES*CNT_W-1:0] zone_wait,
  input  logic [NUM_ZONES-1:0]       zone_ext,
  output logic [CNT_W-1:0]           sel_w,
  output logic                       sel_e,
  output logic                       any_zone
);

  // Scan high to low so the lowest asserted index wins
  always_comb begin
    sel_w    = '0;
    sel_e    = 1'b0;
    any_zone = 1'b0;
    for (int i = NUM_ZONES - 1; i >= 0; i--) begin
      if (!n_zone[i]) begin
        sel_w    = zone_wait[i*CNT_W +: CNT_W];
        sel_e    = zone_ext[i];
        any_zone = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dtack_wait_gen.sv
// dtack_wait_gen: 68K DTACK wait-state generator.
// Optional bus-error timeout: define DTACK_TIMEOUT_EN.
module dtack_wait_gen
  import dtack_wait_pkg::*;
#(
  parameter int NUM_ZONES   = NUM_ZONES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                       CLK,
  input  logic                       nRESET,
  input  logic                       CLK_EN_68K_P,
  input  logic                       nAS,
  input  logic [NUM_ZONES-1:0]       nZONE,
  input  logic [NUM_ZONES*CNT_W-1:0] ZONE_WAIT,
  input  logic [NUM_ZONES-1:0]       ZONE_EXT,
  input  logic                       EXT_RDY,
  output logic                       nDTACK,
  output logic                       WAIT_ACTIVE,
  output logic                       nBERR
);

  logic [CNT_W-1:0] sel_w;
  logic             sel_e;
  logic             any_zone;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             e_q;
  logic             wait_q;
  logic             ack_q;

  logic             zw_sel;
  logic             zw_ack;
  logic             ack;
  logic             berr;

  dtack_zone_prio #(
    .NUM_ZONES (NUM_ZONES),
    .CNT_W     (CNT_W)
  ) u_prio (
    .n_zone    (nZONE),
    .zone_wait (ZONE_WAIT),
    .zone_ext  (ZONE_EXT),
    .sel_w     (sel_w),
    .sel_e     (sel_e),
    .any_zone  (any_zone)
  );

  assign zw_sel = ~any_zone | ((sel_w == '0) & ~sel_e);
  assign zw_ack = (state == ST_IDLE) & zw_sel;
  assign ack    = ack_q | zw_ack;

  // Bus-cycle FSM; counter holds the latched wait count
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      e_q    <= 1'b0;
      wait_q <= 1'b0;
      ack_q  <= 1'b0;
    end else if (CLK_EN_68K_P) begin
      if (nAS) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        e_q    <= 1'b0;
        wait_q <= 1'b0;
        ack_q  <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (sel_w != '0) begin
              state  <= ST_COUNT;
              cnt    <= sel_w;
              e_q    <= sel_e;
              wait_q <= 1'b1;
            end else if (sel_e) begin
              state  <= ST_EXTW;
              e_q    <= 1'b1;
              wait_q <= 1'b1;
            end
          end
          ST_COUNT: begin
            if (cnt == CNT_W'(1)) begin
              if (e_q) begin
                state <= ST_EXTW;
              end else begin
                state  <= ST_ACK;
                wait_q <= 1'b0;
                ack_q  <= 1'b1;
              end
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_EXTW: begin
            if (EXT_RDY) begin
              state  <= ST_ACK;
              wait_q <= 1'b0;
              ack_q  <= 1'b1;
            end
          end
          ST_ACK: begin
            state <= ST_ACK;
          end
          default: begin
            state  <= ST_IDLE;
            wait_q <= 1'b0;
            ack_q  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef DTACK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt;
  logic            berr_q;

  // Count unacknowledged ticks; bus error sticks until nAS rises
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      to_cnt <= '0;
      berr_q <= 1'b0;
    end else if (CLK_EN_68K_P) begin
      if (nAS) begin
        to_cnt <= '0;
        berr_q <= 1'b0;
      end else if (!berr_q && !ack) begin
        to_cnt <= to_cnt + TO_W'(1);
        if (to_cnt == TO_W'(TIMEOUT_CYC - 1))
          berr_q <= 1'b1;
      end
    end
  end

  assign berr = berr_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign berr = 1'b0;
`endif

  assign nDTACK      = ~nRESET | nAS | ~ack | berr;
  assign WAIT_ACTIVE = wait_q;
  assign nBERR       = ~berr;

endmodule

// File: tb/tb_dtack_wait_gen.sv
// tb_dtack_wait_gen: random and directed bus cycles
// against a tick-counting reference model.
module tb_dtack_wait_gen;

  localparam int NZ = 4;
  localparam int CW = 3;
  localparam int TO = 8;

  logic CLK = 1'b0;
  logic nRESET, CLK_EN_68K_P, nAS, EXT_RDY;
  logic [NZ-1:0]    nZONE, ZONE_EXT;
  logic [NZ*CW-1:0] ZONE_WAIT;
  logic nDTACK, WAIT_ACTIVE, nBERR;

  logic [NZ-1:0]    nx_nz, nx_ze;
  logic [NZ*CW-1:0] nx_zw;
  logic             nx_rst;

  int checks = 0;
  int failures = 0;

  bit m_busy, m_e, m_ack, m_berr;
  int m_w, m_k, m_to;

  always #5 CLK = ~CLK;

  dtack_wait_gen #(
    .NUM_ZONES   (NZ),
    .CNT_W       (CW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .CLK          (CLK),
    .nRESET       (nRESET),
    .CLK_EN_68K_P (CLK_EN_68K_P),
    .nAS          (nAS),
    .nZONE        (nZONE),
    .ZONE_WAIT    (ZONE_WAIT),
    .ZONE_EXT     (ZONE_EXT),
    .EXT_RDY      (EXT_RDY),
    .nDTACK       (nDTACK),
    .WAIT_ACTIVE  (WAIT_ACTIVE),
    .nBERR        (nBERR)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int zone_idx();
    for (int i = 0; i < NZ; i++)
      if (!nZONE[i]) return i;
    return -1;
  endfunction

  function automatic int wait_of(input int i);
    return int'(ZONE_WAIT[i*CW +: CW]);
  endfunction

  function automatic bit zw_now();
    int i;
    i = zone_idx();
    return (i < 0) || (wait_of(i) == 0 && !ZONE_EXT[i]);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_e = 0; m_ack = 0; m_berr = 0;
    m_w = 0; m_k = 0; m_to = 0;
  endtask

  task automatic model_tick();
    int i;
    if (nAS) begin
      model_reset();
    end else begin
`ifdef DTACK_TIMEOUT_EN
      begin
        bit acking;
        acking = m_ack || (!m_busy && zw_now());
        if (!acking && !m_berr) begin
          m_to++;
          if (m_to == TO) m_berr = 1;
        end
      end
`endif
      if (!m_busy) begin
        if (!zw_now()) begin
          i = zone_idx();
          m_busy = 1;
          m_w = wait_of(i);
          m_e = ZONE_EXT[i];
          m_k = 0;
          m_ack = 0;
        end
      end else begin
        m_k++;
        if (!m_e) begin
          if (m_k >= m_w) m_ack = 1;
        end else if (m_k > m_w && EXT_RDY) begin
          m_ack = 1;
        end
      end
    end
  endtask

  function automatic logic exp_dtack();
    if (!nRESET || nAS || m_berr) return 1'b1;
    if (m_ack) return 1'b0;
    if (!m_busy && zw_now()) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cyc(input bit as_n, input bit en, input bit rdy);
    @(negedge CLK);
    nRESET = nx_rst;
    nZONE = nx_nz;
    ZONE_WAIT = nx_zw;
    ZONE_EXT = nx_ze;
    nAS = as_n;
    CLK_EN_68K_P = en;
    EXT_RDY = rdy;
    if (!nRESET) model_reset();
    #1;
    check("ndtack", nDTACK, exp_dtack());
    check("wait_active", WAIT_ACTIVE, m_busy && !m_ack);
    check("nberr", nBERR, !m_berr);
    @(posedge CLK);
    if (nRESET && en) model_tick();
  endtask

  task automatic set_zone(input int z, input int w, input bit e);
    nx_nz = '1;
    nx_nz[z] = 1'b0;
    nx_zw[z*CW +: CW] = CW'(w);
    nx_ze[z] = e;
  endtask

  initial begin
    nx_rst = 0; nx_nz = '1; nx_zw = '0; nx_ze = '0;
    nRESET = 0; nZONE = '1; ZONE_WAIT = '0; ZONE_EXT = '0;
    nAS = 1; CLK_EN_68K_P = 0; EXT_RDY = 0;
    model_reset();

    cyc(0, 1, 0);
    cyc(0, 1, 1);
    check("rst_ndtack", nDTACK, 1);
    check("rst_wait", WAIT_ACTIVE, 0);
    check("rst_nberr", nBERR, 1);
    nx_rst = 1;
    cyc(1, 1, 0);

    // zero wait
    cyc(0, 0, 0);
    check("zw_ack", nDTACK, 0);
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 0);

    // zone 1 W=4
    set_zone(1, 4, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0);
    cyc(1, 1, 0);

    // zones 0 and 2, change wait mid-cycle
    nx_nz = 4'b1010; nx_zw = '0; nx_ze = '0;
    nx_zw[0 +: CW] = 3'd2; nx_zw[2*CW +: CW] = 3'd5;
    cyc(0, 1, 0);
    nx_zw[0 +: CW] = 3'd7;
    for (int i = 0; i < 5; i++) cyc(0, 1, 0);
    cyc(1, 1, 0);

    // zone 3 W=1 ext
    nx_zw = '0;
    set_zone(3, 1, 1);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1);
    cyc(1, 1, 0);

    // max wait, abort mid-count
    set_zone(2, 7, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0);
    cyc(1, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0);
    cyc(1, 1, 0);

    // reset mid-EXTW then a normal cycle
    set_zone(0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0);
    nx_rst = 0;
    cyc(0, 1, 1);
    nx_rst = 1;
    cyc(1, 1, 0);
    set_zone(1, 2, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0);
    cyc(1, 1, 0);

    // long ext wait (timeout when enabled)
    set_zone(2, 0, 1);
    for (int i = 0; i < 14; i++) cyc(0, 1, 0);
    cyc(0, 1, 1);
    cyc(1, 1, 0);

    // random bus cycles
    for (int n = 0; n < 400; n++) begin
      int len;
      nx_nz = ($urandom % 3 == 0) ? '1 : NZ'($urandom);
      nx_zw = (NZ*CW)'($urandom);
      nx_ze = NZ'($urandom) & NZ'($urandom);
      len = $urandom_range(1, 25);
      for (int i = 0; i < len; i++) begin
        if ($urandom % 12 == 0) nx_zw = (NZ*CW)'($urandom);
        if ($urandom % 20 == 0) nx_nz = NZ'($urandom);
        nx_rst = ($urandom % 150 != 0);
        cyc(0, $urandom % 3 != 0, $urandom % 5 == 0);
      end
      nx_rst = 1;
      len = $urandom_range(0, 2);
      for (int i = 0; i < len; i++) cyc(1, $urandom % 2 == 0, 0);
      cyc(1, 1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
